// File: rtl/adc_rec_pkg.sv
`default_nettype none
// ============================================================================
// adc_rec_pkg : shared types, sizing helpers and register view for the ADC recorder
// Revision    : 1.0
// ============================================================================
package adc_rec_pkg;

   localparam logic [31:0] ADC_REC_ID = 32'hADC0_4EC1;
   localparam int          WORD_W     = 32;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      CAPTURE = 3'd2,
      FLUSH   = 3'd3,
      DONE    = 3'd4
   } rec_state_t;

   function automatic int calc_sw(input int ports, input int r);
      return ports * r;
   endfunction

   function automatic int calc_spw(input int sw);
      return WORD_W / sw;
   endfunction

   typedef struct packed {
      logic stop;
      logic epoch_sync;
      logic start;
   } rec_ctrl_t;

   typedef struct packed {
      logic done;
      logic busy;
   } rec_status_t;

   typedef struct packed {
      logic [31:0] n_record;
      rec_ctrl_t   control;
      rec_status_t status;
      logic [31:0] count;
   } rec_regs_t;

endpackage
`default_nettype wire

// File: rtl/adc_rec_bram.sv
`default_nettype none
// ============================================================================
// adc_rec_bram : simple dual-port RAM, one write port, one registered read-first read port
// Revision     : 1.0
// ============================================================================
module adc_rec_bram #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH),
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata,
   output logic          o_rvalid
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_rdata;
   logic          r_rvalid;

   // Array itself carries no reset so it maps onto block RAM and survives rst.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= i_re;
         if (i_re) begin
            r_rdata <= r_mem[i_raddr];
         end
      end
   end

   assign o_rdata  = r_rdata;
   assign o_rvalid = r_rvalid;

endmodule
`default_nettype wire

// File: rtl/adc_record_capture.sv
`default_nettype none
// ============================================================================
// adc_record_capture : records a window of packed sign/magnitude ADC samples into BRAM
// Revision           : 1.0
// ============================================================================
module adc_record_capture
   import adc_rec_pkg::*;
#(
   parameter int PORTS = 3,
   parameter int R     = 2,
   parameter int DEPTH = 4096
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [PORTS*R-1:0]       i_adc_data,
   input  logic                     i_adc_valid,
   input  logic                     i_start,
   input  logic                     i_epoch,
   input  logic                     i_epoch_sync,
   input  logic [31:0]              i_n_record,
   input  logic                     i_stop,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [31:0]              o_count,
   input  logic                     i_rd_en,
   input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
   output logic [31:0]              o_rd_data,
   output logic                     o_rd_valid
);

   localparam int          c_SW     = calc_sw(PORTS, R);
   localparam int          c_SPW    = calc_spw(c_SW);
   localparam int          c_PACK_W = c_SW * c_SPW;
   localparam int          c_AW     = $clog2(DEPTH);
   localparam int          c_KW     = (c_SPW > 1) ? $clog2(c_SPW) : 1;
   localparam logic [31:0] c_MAX    = 32'(DEPTH * c_SPW);

   rec_state_t            r_state;
   rec_state_t            w_state_nxt;
   logic                  r_start_q;
   logic                  r_done;
   logic [31:0]           r_count;
   logic [31:0]           r_n_eff;
   logic [c_PACK_W-1:0]   r_pack;
   logic [c_KW-1:0]       r_k;
   logic [c_AW-1:0]       r_wptr;

   logic                  w_start_edge;
   logic                  w_arm;
   logic                  w_take;
   logic                  w_set_done;
   logic                  w_flush_wr;
   logic                  w_last;
   logic                  w_slot_full;
   logic                  w_word_wr;
   logic [31:0]           w_n_eff;
   logic [c_PACK_W-1:0]   w_pack_nxt;
   logic [31:0]           w_wdata;

   assign w_start_edge = i_start & ~r_start_q;
   // The clamp to the RAM capacity is what makes write overflow impossible.
   assign w_n_eff      = (i_n_record > c_MAX) ? c_MAX : i_n_record;
   assign w_last       = (r_count + 32'd1) == r_n_eff;
   assign w_slot_full  = (r_k == c_KW'(c_SPW - 1));
   assign w_pack_nxt   = r_pack | (c_PACK_W'(i_adc_data) << (c_SW * int'(r_k)));
   assign w_word_wr    = w_take & w_slot_full;
   assign w_wdata      = 32'(w_take ? w_pack_nxt : r_pack);

   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_take      = 1'b0;
      w_set_done  = 1'b0;
      w_flush_wr  = 1'b0;
      case (r_state)
         IDLE, DONE: begin
            w_state_nxt = IDLE;
            if (w_start_edge) begin
               w_arm = 1'b1;
               if (i_n_record == 32'd0) begin
                  w_state_nxt = DONE;
                  w_set_done  = 1'b1;
               end else begin
                  w_state_nxt = ARM;
               end
            end
         end
         ARM: begin
            if (i_stop) begin
               w_state_nxt = IDLE;
               w_set_done  = 1'b1;
            end else if (!i_epoch_sync || i_epoch) begin
               // The sample presented on the go clock is sample 0.
               w_take      = i_adc_valid;
               w_state_nxt = (i_adc_valid && w_last) ? FLUSH : CAPTURE;
            end
         end
         CAPTURE: begin
            if (i_stop) begin
               w_state_nxt = FLUSH;
            end else begin
               w_take = i_adc_valid;
               if (i_adc_valid && w_last) begin
                  w_state_nxt = FLUSH;
               end
            end
         end
         FLUSH: begin
            w_flush_wr  = (r_k != '0);
            w_set_done  = 1'b1;
            w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_start_q <= 1'b0;
         r_done    <= 1'b0;
         r_count   <= '0;
         r_n_eff   <= '0;
         r_pack    <= '0;
         r_k       <= '0;
         r_wptr    <= '0;
      end else begin
         r_start_q <= i_start;
         if (w_arm) begin
            r_done  <= 1'b0;
            r_count <= '0;
            r_n_eff <= w_n_eff;
            r_pack  <= '0;
            r_k     <= '0;
            r_wptr  <= '0;
         end
         if (w_set_done) begin
            r_done <= 1'b1;
         end
         if (w_take) begin
            r_count <= r_count + 32'd1;
            if (w_slot_full) begin
               r_pack <= '0;
               r_k    <= '0;
               r_wptr <= r_wptr + 1'b1;
            end else begin
               r_pack <= w_pack_nxt;
               r_k    <= r_k + 1'b1;
            end
         end
         if (w_flush_wr) begin
            r_pack <= '0;
            r_k    <= '0;
            r_wptr <= r_wptr + 1'b1;
         end
      end
   end

   assign o_busy  = (r_state == ARM) || (r_state == CAPTURE) || (r_state == FLUSH);
   assign o_done  = r_done;
   assign o_count = r_count;

   adc_rec_bram #(
      .DEPTH (DEPTH),
      .AW    (c_AW),
      .DW    (32)
   ) u_bram (
      .clk      (clk),
      .rst      (rst),
      .i_we     (w_word_wr | w_flush_wr),
      .i_waddr  (r_wptr),
      .i_wdata  (w_wdata),
      .i_re     (i_rd_en),
      .i_raddr  (i_rd_addr),
      .o_rdata  (o_rd_data),
      .o_rvalid (o_rd_valid)
   );

endmodule
`default_nettype wire
